// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage redirect arbiter, IF flush/branch/stall driver and stale I-cache response filter.
// Optional build macro REDIRECT_REG_EN registers the selected redirect (one-cycle latency).
module fetch_redirect_ctrl #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exc_valid,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    input  logic                  mispred_valid,
    input  logic [ADDR_WIDTH-1:0] mispred_pc,
    input  logic                  id_redir_valid,
    input  logic [ADDR_WIDTH-1:0] id_redir_pc,
    input  logic                  bp_valid,
    input  logic [ADDR_WIDTH-1:0] bp_pc,
    input  logic                  req_fire,
    input  logic                  resp_valid,
    output logic                  flush,
    output logic [ADDR_WIDTH-1:0] flush_pc,
    output logic                  branch,
    output logic [ADDR_WIDTH-1:0] predict_pc,
    output logic                  stall,
    output logic                  resp_drop,
    output logic                  kill_id,
    output logic                  kill_ex
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        RUN,
        DRAIN
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic                  src_redir;
    logic [ADDR_WIDTH-1:0] src_pc;
    logic                  redir;

    always_comb begin
        src_redir = exc_valid | mispred_valid | id_redir_valid;
        src_pc    = '0;
        if (exc_valid) begin
            src_pc = exc_pc;
        end else if (mispred_valid) begin
            src_pc = mispred_pc;
        end else if (id_redir_valid) begin
            src_pc = id_redir_pc;
        end
    end

`ifdef REDIRECT_REG_EN
    logic                  redir_q, redir_d;
    logic [ADDR_WIDTH-1:0] redir_pc_q, redir_pc_d;
    logic                  kill_id_q, kill_id_d;
    logic                  kill_ex_q, kill_ex_d;

    // A source arriving while a registered flush issues simply lands in the next cycle's slot.
    always_comb begin
        redir_d    = src_redir;
        redir_pc_d = src_pc;
        kill_ex_d  = exc_valid;
        kill_id_d  = exc_valid | mispred_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
            kill_id_q  <= 1'b0;
            kill_ex_q  <= 1'b0;
        end else begin
            redir_q    <= redir_d;
            redir_pc_q <= redir_pc_d;
            kill_id_q  <= kill_id_d;
            kill_ex_q  <= kill_ex_d;
        end
    end

    assign redir    = redir_q;
    assign flush_pc = redir_pc_q;
    assign kill_id  = kill_id_q;
    assign kill_ex  = kill_ex_q;
    assign branch   = bp_valid & ~src_redir & ~redir_q;
`else
    assign redir    = src_redir;
    assign flush_pc = src_pc;
    assign kill_id  = exc_valid | mispred_valid;
    assign kill_ex  = exc_valid;
    assign branch   = bp_valid & ~src_redir;
`endif

    assign flush      = redir;
    assign predict_pc = bp_pc;
    assign stall      = (state_q == DRAIN) | (out_cnt_q == MAX_CNT);

    // Protocol violations leave the counter saturated rather than wrapping.
    always_comb begin
        out_cnt_d = out_cnt_q;
        if (req_fire && !resp_valid && out_cnt_q != MAX_CNT) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end else if (resp_valid && !req_fire && out_cnt_q != '0) begin
            out_cnt_d = out_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        resp_drop  = 1'b0;
        case (state_q)
            RUN: begin
                resp_drop = resp_valid & redir;
                if (redir) begin
                    drop_cnt_d = out_cnt_d;
                    if (out_cnt_d != '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                resp_drop = resp_valid;
                if (redir) begin
                    drop_cnt_d = out_cnt_d;
                end else if (resp_valid && drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CNT_W'(1);
                end
                if (drop_cnt_d == '0) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    req_overflow_a: assert property (@(posedge clk) disable iff (!rst)
        !(req_fire && out_cnt_q == MAX_CNT));
    resp_underflow_a: assert property (@(posedge clk) disable iff (!rst)
        !(resp_valid && out_cnt_q == '0));
    drop_le_out_a: assert property (@(posedge clk) disable iff (!rst)
        drop_cnt_q <= out_cnt_q);

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed self-checking bench for fetch_redirect_ctrl (default build, or REDIRECT_REG_EN build).
module tb_fetch_redirect_ctrl;

    localparam int ADDR_WIDTH = 32;
    localparam logic [ADDR_WIDTH-1:0] EXC_PC = 32'h1c00_0100;
    localparam logic [ADDR_WIDTH-1:0] MIS_PC = 32'h1c00_0200;
    localparam logic [ADDR_WIDTH-1:0] ID_PC  = 32'h1c00_0300;
    localparam logic [ADDR_WIDTH-1:0] BP_PC  = 32'h1c00_0400;

    logic                  clk;
    logic                  rst;
    logic                  exc_valid, mispred_valid, id_redir_valid, bp_valid;
    logic [ADDR_WIDTH-1:0] exc_pc, mispred_pc, id_redir_pc, bp_pc;
    logic                  req_fire, resp_valid;
    logic                  flush, branch, stall, resp_drop, kill_id, kill_ex;
    logic [ADDR_WIDTH-1:0] flush_pc, predict_pc;

    int assertCount;
    int failCount;

    fetch_redirect_ctrl #(
        .MAX_OUTSTANDING(4),
        .ADDR_WIDTH     (ADDR_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .exc_valid     (exc_valid),
        .exc_pc        (exc_pc),
        .mispred_valid (mispred_valid),
        .mispred_pc    (mispred_pc),
        .id_redir_valid(id_redir_valid),
        .id_redir_pc   (id_redir_pc),
        .bp_valid      (bp_valid),
        .bp_pc         (bp_pc),
        .req_fire      (req_fire),
        .resp_valid    (resp_valid),
        .flush         (flush),
        .flush_pc      (flush_pc),
        .branch        (branch),
        .predict_pc    (predict_pc),
        .stall         (stall),
        .resp_drop     (resp_drop),
        .kill_id       (kill_id),
        .kill_ex       (kill_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after the rising edge; the caller samples at the following falling edge.
    task automatic applyStimulus(input logic e, input logic m, input logic i, input logic b,
                                 input logic rf, input logic rv);
        @(posedge clk);
        #1;
        exc_valid      = e;
        mispred_valid  = m;
        id_redir_valid = i;
        bp_valid       = b;
        req_fire       = rf;
        resp_valid     = rv;
        @(negedge clk);
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [ADDR_WIDTH-1:0] observed,
                               input logic [ADDR_WIDTH-1:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        assertCount    = 0;
        failCount      = 0;
        rst            = 1'b0;
        exc_valid      = 1'b0;
        mispred_valid  = 1'b0;
        id_redir_valid = 1'b0;
        bp_valid       = 1'b0;
        req_fire       = 1'b0;
        resp_valid     = 1'b0;
        exc_pc         = EXC_PC;
        mispred_pc     = MIS_PC;
        id_redir_pc    = ID_PC;
        bp_pc          = BP_PC;

        repeat (2) @(negedge clk);
        $display("[TB] reset state");
        checkBit("rst_flush", flush, 1'b0);
        checkOutput("rst_flush_pc", flush_pc, '0);
        checkBit("rst_branch", branch, 1'b0);
        checkBit("rst_stall", stall, 1'b0);
        checkBit("rst_resp_drop", resp_drop, 1'b0);
        checkBit("rst_kill_id", kill_id, 1'b0);
        checkBit("rst_kill_ex", kill_ex, 1'b0);
        rst = 1'b1;

`ifdef REDIRECT_REG_EN
        $display("[TB] registered redirect latency");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checkBit("reg_n_flush", flush, 1'b0);
        checkBit("reg_n_branch", branch, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkBit("reg_n1_flush", flush, 1'b1);
        checkOutput("reg_n1_flush_pc", flush_pc, MIS_PC);
        checkBit("reg_n1_kill_id", kill_id, 1'b1);
        checkBit("reg_n1_kill_ex", kill_ex, 1'b0);
        checkBit("reg_n1_branch", branch, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkBit("reg_n2_flush", flush, 1'b0);
        checkBit("reg_n2_branch", branch, 1'b1);
        checkOutput("reg_predict_pc", predict_pc, BP_PC);
`else
        $display("[TB] exception beats mispredict");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkBit("prio_flush", flush, 1'b1);
        checkOutput("prio_flush_pc", flush_pc, EXC_PC);
        checkBit("prio_kill_ex", kill_ex, 1'b1);
        checkBit("prio_kill_id", kill_id, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkBit("prio_no_drain", stall, 1'b0);

        $display("[TB] predictor hint vs ID redirect");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkBit("id_branch", branch, 1'b0);
        checkBit("id_flush", flush, 1'b1);
        checkOutput("id_flush_pc", flush_pc, ID_PC);
        checkBit("id_kill_id", kill_id, 1'b0);
        checkBit("id_kill_ex", kill_ex, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkBit("bp_branch", branch, 1'b1);
        checkBit("bp_flush", flush, 1'b0);
        checkOutput("bp_predict_pc", predict_pc, BP_PC);

        $display("[TB] mispredict with two in flight plus one fired");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkBit("mis_flush", flush, 1'b1);
        checkBit("mis_stall_same", stall, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkBit("drain_stall", stall, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkBit("drain_drop1", resp_drop, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkBit("drain_gap_drop", resp_drop, 1'b0);
        checkBit("drain_gap_stall", stall, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkBit("drain_drop2", resp_drop, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkBit("drain_drop3", resp_drop, 1'b1);
        checkBit("drain_stall_last", stall, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkBit("drain_done_stall", stall, 1'b0);

        $display("[TB] outstanding limit");
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkBit("max_stall_before", stall, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkBit("max_stall", stall, 1'b1);
        checkBit("max_resp_keep", resp_drop, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkBit("max_stall_release", stall, 1'b0);
        repeat (3) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            checkBit("max_tail_keep", resp_drop, 1'b0);
        end

        $display("[TB] reset in the middle of a drain");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkBit("mid_flush", flush, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkBit("mid_drain_stall", stall, 1'b1);
        rst = 1'b0;
        #1;
        checkBit("mid_async_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        checkBit("mid_edge_stall", stall, 1'b0);
        checkBit("mid_edge_flush", flush, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkBit("post_rst_flush", flush, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkBit("post_rst_no_drain", stall, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
